bram_burst_reader: RTL and testbench



---
 rtl/bram_rd_pkg.sv | 18 +
 rtl/bram_rd_fifo.sv | 65 ++++++
 rtl/bram_burst_reader.sv | 126 ++++++++++++
 tb/tb_bram_burst_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the BRAM port-B burst reader.
package bram_rd_pkg;

    localparam int unsigned BRAM_DATA_W = 32;
    localparam int unsigned BRAM_WEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic                   last;
        logic [BRAM_DATA_W-1:0] data;
    } rd_entry_t;

endpackage

// File: rtl/bram_rd_fifo.sv
// Small synchronous FIFO of read entries; head is visible combinationally.
module bram_rd_fifo
    import bram_rd_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  rd_entry_t                  i_push_data,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output rd_entry_t                  o_head
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rd_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_pop = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            unique case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/bram_burst_reader.sv
// BRAM port-B burst reader: issues sequential reads and streams the words out with a last flag.
module bram_burst_reader
    import bram_rd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [ADDR_WIDTH:0]    cmd_len,
    output logic                   BRAM_ENB,
    output logic [BRAM_WEN_W-1:0]  BRAM_WENB,
    output logic [ADDR_WIDTH-1:0]  BRAM_AddrB,
    output logic [BRAM_DATA_W-1:0] BRAM_DoutB,
    input  logic [BRAM_DATA_W-1:0] BRAM_DinB,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BRAM_DATA_W-1:0] out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_t             r_state;
    rd_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;

    logic                  w_issue;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_empty;
    logic                  w_full;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W:0]        w_occupancy;
    logic [CNT_W:0]        w_limit;
    logic                  w_last_word;
    rd_entry_t             w_head;
    rd_entry_t             w_push_data;

    assign w_pop       = ~w_empty & out_ready;
    assign w_last_word = (r_remaining == (ADDR_WIDTH+1)'(1));

    // Reserve a FIFO slot for every read in flight so a capture never stalls.
    assign w_occupancy = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
    assign w_limit     = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(w_pop);
    assign w_issue     = (r_state == ISSUE) && (r_remaining != '0) && (w_occupancy < w_limit);

    assign w_push      = r_inflight & (~w_full | w_pop);
    assign w_push_data = {r_inflight_last, BRAM_DinB};

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_issue && w_last_word) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_inflight && (w_empty || ((w_count == CNT_W'(1)) && w_pop))) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_last_word;
            if ((r_state == IDLE) && cmd_valid) begin
                r_addr      <= cmd_addr;
                r_remaining <= cmd_len;
            end else if (w_issue) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_head      (w_head)
    );

    assign cmd_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign BRAM_ENB   = w_issue;
    assign BRAM_AddrB = r_addr;
    assign BRAM_WENB  = '0;
    assign BRAM_DoutB = '0;
    assign out_valid  = ~w_empty;
    // Gate the head so a stale FIFO entry never shows on the bus after reset.
    assign out_data   = w_empty ? '0 : w_head.data;
    assign out_last   = ~w_empty & w_head.last;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader with a behavioural BRAM and word-queue reference model.
module tb_bram_burst_reader;
    import bram_rd_pkg::*;

    localparam int AW    = 7;
    localparam int WORDS = 128;
    localparam int FD    = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          BRAM_ENB;
    logic [3:0]    BRAM_WENB;
    logic [AW-1:0] BRAM_AddrB;
    logic [31:0]   BRAM_DoutB;
    logic [31:0]   BRAM_DinB;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [31:0] mem [WORDS];
    logic [31:0] bram_q;

    typedef struct {
        int          addr;
        int          len;
        int          mode;
        logic [31:0] first_word;
        logic [31:0] last_word;
        int          first_rel;
        int          last_rel;
        int          done_rel;
    } vec_t;

    vec_t vecs [6];

    bram_burst_reader #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .BRAM_ENB   (BRAM_ENB),
        .BRAM_WENB  (BRAM_WENB),
        .BRAM_AddrB (BRAM_AddrB),
        .BRAM_DoutB (BRAM_DoutB),
        .BRAM_DinB  (BRAM_DinB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // BRAM read port: data reflects the address sampled at the previous edge, regardless of enable.
    always @(posedge CLK) begin
        cyc    <= cyc + 1;
        bram_q <= mem[BRAM_AddrB];
    end
    assign BRAM_DinB = bram_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_enb"}, BRAM_ENB, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random ready.
    task automatic do_burst(input int addr, input int len, input int mode,
                            output int first_rel, output int last_rel, output int done_rel,
                            output logic [31:0] first_word, output logic [31:0] last_word,
                            output int n_last);
        logic [32:0] exp_q [$];
        logic [32:0] got;
        logic [32:0] want;
        logic [32:0] prev_word;
        logic        prev_stall;
        int          t0;
        int          issues;
        int          pops;
        int          budget;
        bit          done;

        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), mem[(addr + i) % WORDS]});
        end
        first_rel  = -1;
        last_rel   = -1;
        done_rel   = -1;
        first_word = '0;
        last_word  = '0;
        n_last     = 0;
        issues     = 0;
        pops       = 0;
        prev_stall = 1'b0;
        prev_word  = '0;
        done       = 1'b0;
        budget     = 4 * len + 20;

        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW + 1)'(len);
        out_ready = 1'b1;
        #1;
        check("cmd_ready_at_cmd", cmd_ready, 1);
        t0 = cyc;

        for (int j = 0; j < budget && !done; j++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (j % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check("wenb_zero", BRAM_WENB, 0);
            check("doutb_zero", BRAM_DoutB, 0);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_last, out_data}, prev_word);
            end
            if (BRAM_ENB) begin
                if (issues == 0) begin
                    check("first_issue_rel", cyc - t0, 1);
                end
                check("issue_addr", BRAM_AddrB, (addr + issues) % WORDS);
                issues++;
            end
            if (out_valid && out_ready) begin
                got = {out_last, out_data};
                if (exp_q.size() == 0) begin
                    check("extra_word_count", pops + 1, len);
                end else begin
                    want = exp_q.pop_front();
                    check("word", got, want);
                    if (pops == 0) begin
                        first_rel  = cyc - t0;
                        first_word = out_data;
                    end
                    last_rel = cyc - t0;
                    if (out_last) begin
                        n_last++;
                        last_word = out_data;
                    end
                end
                pops++;
            end
            check("outstanding_le_depth", (issues - pops <= FD), 1);
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
            if (exp_q.size() == 0 && cmd_ready) begin
                done_rel = cyc - t0;
                done     = 1'b1;
            end
        end
        check("burst_completed", done, 1);
        check("issue_count", issues, len);
        check("pop_count", pops, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1);
    end

    initial begin
        int          fr;
        int          lr;
        int          dr;
        int          nl;
        int          hs;
        logic [31:0] fw;
        logic [31:0] lw;

        for (int i = 0; i < WORDS; i++) begin
            mem[i] = 32'(i + 100);
        end
        vecs[0] = '{addr: 4,   len: 5,   mode: 0, first_word: 104, last_word: 108,
                    first_rel: 3, last_rel: 7,   done_rel: 8};
        vecs[1] = '{addr: 126, len: 4,   mode: 0, first_word: 226, last_word: 101,
                    first_rel: 3, last_rel: 6,   done_rel: 7};
        vecs[2] = '{addr: 4,   len: 5,   mode: 1, first_word: 104, last_word: 108,
                    first_rel: -1, last_rel: -1, done_rel: -1};
        vecs[3] = '{addr: 0,   len: 128, mode: 0, first_word: 100, last_word: 227,
                    first_rel: 3, last_rel: 130, done_rel: 131};
        vecs[4] = '{addr: 10,  len: 1,   mode: 0, first_word: 110, last_word: 110,
                    first_rel: 3, last_rel: 3,   done_rel: 4};
        vecs[5] = '{addr: 127, len: 2,   mode: 1, first_word: 227, last_word: 100,
                    first_rel: -1, last_rel: -1, done_rel: -1};

        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_idle_outputs("reset");
        check("reset_addrb", BRAM_AddrB, 0);
        check("reset_wenb", BRAM_WENB, 0);
        RST = 1'b0;

        for (int k = 0; k < 6; k++) begin
            do_burst(vecs[k].addr, vecs[k].len, vecs[k].mode, fr, lr, dr, fw, lw, nl);
            check("vec_first_word", fw, vecs[k].first_word);
            check("vec_last_word", lw, vecs[k].last_word);
            check("vec_one_last", nl, 1);
            if (vecs[k].first_rel >= 0) begin
                check("vec_first_rel", fr, vecs[k].first_rel);
                check("vec_last_rel", lr, vecs[k].last_rel);
                check("vec_done_rel", dr, vecs[k].done_rel);
            end
        end

        // Zero-length command: accepted but produces nothing.
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(9);
        cmd_len   = '0;
        out_ready = 1'b1;
        #1;
        check("len0_cmd_ready", cmd_ready, 1);
        check("len0_enb", BRAM_ENB, 0);
        for (int j = 0; j < 5; j++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            check_idle_outputs("len0");
        end

        // Reset after the third delivered word aborts the burst cleanly.
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(20);
        cmd_len   = (AW + 1)'(8);
        out_ready = 1'b1;
        hs        = 0;
        for (int j = 0; j < 20 && hs < 3; j++) begin
            @(negedge CLK);
            cmd_valid = 1'b0;
            #1;
            if (out_valid && out_ready) begin
                check("rst_seq_word", out_data, mem[20 + hs]);
                hs++;
            end
        end
        check("rst_seq_three_words", hs, 3);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check_idle_outputs("post_rst");
        check("post_rst_addrb", BRAM_AddrB, 0);
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            #1;
            check("post_rst_no_valid", out_valid, 0);
            check("post_rst_no_enb", BRAM_ENB, 0);
        end
        do_burst(0, 2, 0, fr, lr, dr, fw, lw, nl);
        check("after_rst_first", fw, 100);
        check("after_rst_last", lw, 101);
        check("after_rst_first_rel", fr, 3);

        // Randomised contents and bursts against the word-queue model.
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = $urandom;
        end
        for (int k = 0; k < 30; k++) begin
            do_burst(int'($urandom_range(0, WORDS - 1)), int'($urandom_range(1, 24)),
                     (k % 4 == 0) ? 1 : 2, fr, lr, dr, fw, lw, nl);
            check("rand_one_last", nl, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
